// File: rtl/led_trail_fader.sv
`default_nettype none
// ============================================================================
// Module   : led_trail_fader
// Purpose  : Comet-trail stage for a 4-LED running-light chaser. A lit LED
//            is solid on. When the chaser leaves it, the LED fades out by
//            PWM dimming in fixed steps on a shared decay tick.
// Revision : 1.0 - initial release
// ============================================================================
module led_trail_fader #(
  parameter int PWM_BITS   = 8,
  parameter int BRIGHT_MAX = 255,
  parameter int DECAY_DIV  = 500_000,
  parameter int DECAY_STEP = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] pat_in,
  input  logic       dim_en,
  output logic [3:0] led,
  output logic       busy
);

  localparam int NCH   = 4;
  localparam int DEC_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  localparam logic [PWM_BITS-1:0] BRIGHT_LOAD = PWM_BITS'(BRIGHT_MAX);
  localparam logic [DEC_W-1:0]    DEC_LAST    = DEC_W'(DECAY_DIV - 1);

  // A step at least as large as the full brightness range always empties
  // the channel in one tick; the truncated constant is only used otherwise.
  localparam bit                  STEP_FITS   = (DECAY_STEP < (2 ** PWM_BITS));
  localparam logic [PWM_BITS-1:0] STEP        = PWM_BITS'(DECAY_STEP);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ON   = 2'd1,
    ST_FADE = 2'd2
  } ch_state_t;

  logic [3:0]          pat_q;
  logic [DEC_W-1:0]    dec_cnt;
  logic                dec_tick;
  logic [PWM_BITS-1:0] pwm_cnt;

  ch_state_t           state      [NCH];
  logic [PWM_BITS-1:0] bright     [NCH];
  ch_state_t           state_nxt  [NCH];
  logic [PWM_BITS-1:0] bright_nxt [NCH];
  logic [NCH-1:0]      led_nxt;
  logic [NCH-1:0]      fade_nxt;

  assign dec_tick = (dec_cnt == DEC_LAST);

  // Register the chaser pattern once before it feeds the channel logic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q <= 4'b1111;
    end else begin
      pat_q <= pat_in;
    end
  end

  // Free-running decay prescaler, one tick every DECAY_DIV cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dec_cnt <= '0;
    end else if (dec_tick) begin
      dec_cnt <= '0;
    end else begin
      dec_cnt <= dec_cnt + DEC_W'(1);
    end
  end

  // Free-running PWM ramp shared by all fading channels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Per-channel next state/brightness, plus the LED level that the new
  // state implies, so the output edge already shows the updated state.
  always_comb begin
    led_nxt  = '1;
    fade_nxt = '0;
    for (int i = 0; i < NCH; i++) begin
      state_nxt[i]  = state[i];
      bright_nxt[i] = bright[i];
      if (!pat_q[i]) begin
        // Relight wins over everything, including a coincident tick.
        state_nxt[i]  = ST_ON;
        bright_nxt[i] = BRIGHT_LOAD;
      end else begin
        case (state[i])
          ST_ON: begin
            if (dim_en) begin
              state_nxt[i] = ST_FADE;
            end else begin
              state_nxt[i]  = ST_OFF;
              bright_nxt[i] = '0;
            end
          end
          ST_FADE: begin
            if (!dim_en) begin
              state_nxt[i]  = ST_OFF;
              bright_nxt[i] = '0;
            end else if (dec_tick) begin
              if (STEP_FITS && (bright[i] > STEP)) begin
                bright_nxt[i] = bright[i] - STEP;
              end else begin
                bright_nxt[i] = '0;
                state_nxt[i]  = ST_OFF;
              end
            end
          end
          default: begin
          end
        endcase
      end

      fade_nxt[i] = (state_nxt[i] == ST_FADE);
      case (state_nxt[i])
        ST_ON:   led_nxt[i] = 1'b0;
        ST_FADE: led_nxt[i] = !(bright_nxt[i] > pwm_cnt);
        default: led_nxt[i] = 1'b1;
      endcase
    end
  end

  // Channel state machines: commit the next state and brightness.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        state[i]  <= ST_OFF;
        bright[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state[i]  <= state_nxt[i];
        bright[i] <= bright_nxt[i];
      end
    end
  end

  // Registered board outputs (active-low LEDs) and the fade-activity flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led  <= 4'b1111;
      busy <= 1'b0;
    end else begin
      led  <= led_nxt;
      busy <= |fade_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_trail_fader.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_trail_fader
// Purpose  : Directed and random stimulus for led_trail_fader, compared each
//            cycle against a behavioural model of the channel rules, plus an
//            independent two-cycle pass-through reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_trail_fader;

  localparam int PWM_BITS   = 4;
  localparam int BRIGHT_MAX = 15;
  localparam int DECAY_DIV  = 4;
  localparam int DECAY_STEP = 5;
  localparam int PWM_MOD    = 1 << PWM_BITS;

  localparam int M_OFF  = 0;
  localparam int M_ON   = 1;
  localparam int M_FADE = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] pat_in;
  logic       dim_en;
  logic [3:0] led;
  logic       busy;
  bit         clk_run = 1'b0;

  led_trail_fader #(
    .PWM_BITS  (PWM_BITS),
    .BRIGHT_MAX(BRIGHT_MAX),
    .DECAY_DIV (DECAY_DIV),
    .DECAY_STEP(DECAY_STEP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pat_in(pat_in),
    .dim_en(dim_en),
    .led   (led),
    .busy  (busy)
  );

  // Clock can be held still to show the reset needs no edge.
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  // Behavioural model state.
  int         m_state  [4];
  int         m_bright [4];
  logic [3:0] m_patq;
  logic [3:0] m_led;
  logic       m_busy;
  int         m_dec;
  int         m_pwm;
  logic [3:0] pat_d1;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_state[i]  = M_OFF;
      m_bright[i] = 0;
    end
    m_patq = 4'b1111;
    m_led  = 4'b1111;
    m_busy = 1'b0;
    m_dec  = 0;
    m_pwm  = 0;
    pat_d1 = 4'b1111;
  endtask

  // One clock edge of the specified behaviour, from pre-edge values.
  task automatic model_step();
    bit tick;
    tick   = (m_dec == DECAY_DIV - 1);
    m_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m_patq[i] == 1'b0) begin
        m_state[i]  = M_ON;
        m_bright[i] = BRIGHT_MAX;
      end else if (m_state[i] == M_ON) begin
        if (dim_en) m_state[i] = M_FADE;
        else begin
          m_state[i]  = M_OFF;
          m_bright[i] = 0;
        end
      end else if (m_state[i] == M_FADE && !dim_en) begin
        m_state[i]  = M_OFF;
        m_bright[i] = 0;
      end else if (m_state[i] == M_FADE && tick) begin
        m_bright[i] = (m_bright[i] > DECAY_STEP) ? m_bright[i] - DECAY_STEP : 0;
        if (m_bright[i] == 0) m_state[i] = M_OFF;
      end
      if (m_state[i] == M_ON)        m_led[i] = 1'b0;
      else if (m_state[i] == M_FADE) m_led[i] = (m_bright[i] > m_pwm) ? 1'b0 : 1'b1;
      else                           m_led[i] = 1'b1;
      if (m_state[i] == M_FADE) m_busy = 1'b1;
    end
    m_patq = pat_in;
    m_dec  = (m_dec + 1) % DECAY_DIV;
    m_pwm  = (m_pwm + 1) % PWM_MOD;
  endtask

  // Advance one clock, check outputs #1 after the edge, return on the negedge.
  task automatic cycle();
    logic [3:0] pt_exp;
    logic       dim_at_edge;
    @(posedge clk);
    pt_exp      = pat_d1;
    dim_at_edge = dim_en;
    if (!reset) begin
      model_reset();
    end else begin
      model_step();
      pat_d1 = pat_in;
    end
    #1;
    check("led", led, m_led);
    check("busy", {3'b000, busy}, {3'b000, m_busy});
    if (reset && !dim_at_edge) begin
      check("passthru_led", led, pt_exp);
      check("passthru_busy", {3'b000, busy}, 4'b0000);
    end
    @(negedge clk);
  endtask

  task automatic chaser_round(input int hold);
    logic [3:0] seq [4];
    seq[0] = 4'b1110;
    seq[1] = 4'b1101;
    seq[2] = 4'b1011;
    seq[3] = 4'b0111;
    for (int s = 0; s < 4; s++) begin
      pat_in = seq[s];
      repeat (hold) cycle();
    end
  endtask

  initial begin
    pat_in = 4'b1111;
    dim_en = 1'b1;
    reset  = 1'b1;
    model_reset();

    // Reset without any clock edge.
    #1 reset = 1'b0;
    #1;
    check("rst_noclk_led", led, 4'b1111);
    check("rst_noclk_busy", {3'b000, busy}, 4'b0000);

    // Hold reset with the clock running, then release.
    clk_run = 1'b1;
    repeat (3) cycle();
    reset = 1'b1;
    repeat (2) cycle();
    check("rst_rel_led", led, 4'b1111);

    // Basic fade.
    pat_in = 4'b1110;
    cycle();
    cycle();
    check("lit_2nd_edge", led, 4'b1110);
    pat_in = 4'b1111;
    cycle();
    cycle();
    check("fade_busy", {3'b000, busy}, 4'b0001);
    repeat (16) cycle();
    check("fade_done_led", led, 4'b1111);
    check("fade_done_busy", {3'b000, busy}, 4'b0000);

    // Relight on a tick edge while bright is 10.
    pat_in = 4'b1110;
    cycle();
    cycle();
    pat_in = 4'b1111;
    cycle();
    cycle();
    for (int k = 0; k < 12 && m_bright[0] != 10; k++) cycle();
    check("reach_b10", (m_bright[0] == 10) ? 4'd1 : 4'd0, 4'd1);
    for (int k = 0; k < 8 && m_dec != DECAY_DIV - 2; k++) cycle();
    pat_in = 4'b1110;
    cycle();
    cycle();
    check("relight_led", led, 4'b1110);
    check("relight_busy", {3'b000, busy}, 4'b0000);
    repeat (3) cycle();
    pat_in = 4'b1111;
    repeat (20) cycle();

    // Pass-through.
    dim_en = 1'b0;
    chaser_round(8);
    chaser_round(8);
    pat_in = 4'b1111;
    repeat (4) cycle();

    // Trail.
    dim_en = 1'b1;
    chaser_round(8);
    chaser_round(8);
    pat_in = 4'b1111;
    repeat (20) cycle();
    check("trail_end_busy", {3'b000, busy}, 4'b0000);

    // Kill a fade by dropping dim_en.
    pat_in = 4'b1110;
    cycle();
    cycle();
    pat_in = 4'b1111;
    repeat (3) cycle();
    dim_en = 1'b0;
    cycle();
    check("kill_led", led, 4'b1111);
    check("kill_busy", {3'b000, busy}, 4'b0000);

    // Asynchronous reset mid-fade.
    dim_en = 1'b1;
    pat_in = 4'b1101;
    cycle();
    cycle();
    pat_in = 4'b1111;
    repeat (3) cycle();
    check("pre_rst_busy", {3'b000, busy}, {3'b000, m_busy});
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_rst_led", led, 4'b1111);
    check("async_rst_busy", {3'b000, busy}, 4'b0000);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) cycle();

    // Random chaser-like patterns and dimming toggles.
    repeat (60) begin
      pat_in = 4'($urandom);
      dim_en = ($urandom_range(0, 7) != 0);
      repeat ($urandom_range(1, 8)) cycle();
    end
    pat_in = 4'b1111;
    dim_en = 1'b1;
    repeat (20) cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
